// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and entry format for the expanded adder datapath.
package adder_pkg;
  localparam int SUM_W = 8;
  localparam logic [7:0] DROP_MAX = 8'hFF;
  typedef struct packed {
    logic carry;
    logic [SUM_W-1:0] sum;
  } sum_entry_t;
endpackage

// File: rtl/sum_result_fifo.sv
// sum_result_fifo: first-word-fall-through capture FIFO for adder results.
// Results arriving while full are dropped and counted in a saturating counter.
module sum_result_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Data_ready,
  input  logic [SUM_W-1:0] Sum_result,
  input  logic             Sum_carry,
  input  logic             Out_ready,
  input  logic             Clr_stats,
  output logic             Out_valid,
  output logic [SUM_W-1:0] Out_sum,
  output logic             Out_carry,
  output logic [CNT_W-1:0] Fifo_count,
  output logic             Fifo_full,
  output logic             Fifo_empty,
  output logic [7:0]       Drop_count
);
  localparam int PW = $clog2(DEPTH);

  sum_entry_t       r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_drop;
  logic             w_full, w_empty, w_pop, w_push, w_drop;

  assign w_full  = r_count == CNT_W'(DEPTH);
  assign w_empty = r_count == '0;
  assign w_pop   = !w_empty && Out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push  = Data_ready && (!w_full || w_pop);
  assign w_drop  = Data_ready && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{carry: Sum_carry, sum: Sum_result};
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop) r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (Clr_stats) r_drop <= '0;
      else if (w_drop && r_drop != DROP_MAX) r_drop <= r_drop + 8'd1;
    end
  end

  assign Out_valid  = !w_empty;
  assign Out_sum    = r_mem[r_rptr].sum;
  assign Out_carry  = r_mem[r_rptr].carry;
  assign Fifo_count = r_count;
  assign Fifo_full  = w_full;
  assign Fifo_empty = w_empty;
  assign Drop_count = r_drop;
endmodule

// File: tb/tb_sum_result_fifo.sv
// tb_sum_result_fifo: scoreboard-driven checks of the adder result FIFO.
module tb_sum_result_fifo;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 0;
  logic             reset_n = 0;
  logic             Data_ready = 0;
  logic [7:0]       Sum_result = 0;
  logic             Sum_carry = 0;
  logic             Out_ready = 0;
  logic             Clr_stats = 0;
  logic             Out_valid;
  logic [7:0]       Out_sum;
  logic             Out_carry;
  logic [CNT_W-1:0] Fifo_count;
  logic             Fifo_full;
  logic             Fifo_empty;
  logic [7:0]       Drop_count;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  int exp_drop = 0;

  sum_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .Data_ready(Data_ready), .Sum_result(Sum_result),
    .Sum_carry(Sum_carry), .Out_ready(Out_ready), .Clr_stats(Clr_stats),
    .Out_valid(Out_valid), .Out_sum(Out_sum), .Out_carry(Out_carry),
    .Fifo_count(Fifo_count), .Fifo_full(Fifo_full), .Fifo_empty(Fifo_empty),
    .Drop_count(Drop_count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus: checks the head against the scoreboard before the
  // edge, advances the model, then checks occupancy and drop state after it.
  task automatic cycle(input logic dr, input logic [8:0] v, input logic rdy, input logic clr);
    int sz;
    bit pop;
    sz = exp_q.size();
    pop = rdy && sz > 0;
    Data_ready = dr; {Sum_carry, Sum_result} = v; Out_ready = rdy; Clr_stats = clr;
    #1;
    checks++;
    if (Out_valid !== (sz > 0)) begin
      errors++; $display("FAIL valid: got %b expected %b", Out_valid, sz > 0);
    end
    if (sz > 0) begin
      checks++;
      if ({Out_carry, Out_sum} !== exp_q[0]) begin
        errors++; $display("FAIL head: got %h expected %h", {Out_carry, Out_sum}, exp_q[0]);
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (dr && (sz < DEPTH || pop)) exp_q.push_back(v);
    if (clr) exp_drop = 0;
    else if (dr && sz == DEPTH && !pop && exp_drop < 255) exp_drop++;
    @(posedge clk); #1;
    Data_ready = 0; Out_ready = 0; Clr_stats = 0;
    checks++;
    if (Fifo_count !== CNT_W'(exp_q.size()) || Fifo_full !== (exp_q.size() == DEPTH)
        || Fifo_empty !== (exp_q.size() == 0)) begin
      errors++;
      $display("FAIL count: got cnt=%0d full=%b empty=%b expected cnt=%0d",
               Fifo_count, Fifo_full, Fifo_empty, exp_q.size());
    end
    checks++;
    if (Drop_count !== 8'(exp_drop)) begin
      errors++; $display("FAIL drop: got %0d expected %0d", Drop_count, exp_drop);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 9'h0, 1, 0);
  endtask

  task automatic test_reset();
    reset_n = 0;
    #3;
    checks++;
    if ({Out_valid, Out_sum, Out_carry, Fifo_count, Fifo_empty, Fifo_full, Drop_count}
        !== {1'b0, 8'd0, 1'b0, CNT_W'(0), 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset: got v=%b s=%h c=%b n=%0d e=%b f=%b d=%0d", Out_valid, Out_sum,
               Out_carry, Fifo_count, Fifo_empty, Fifo_full, Drop_count);
    end
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic test_single();
    cycle(1, 9'h106, 0, 0);
    checks++;
    if ({Out_valid, Out_carry, Out_sum, Fifo_count} !== {1'b1, 1'b1, 8'd6, CNT_W'(1)}) begin
      errors++;
      $display("FAIL single: got v=%b c=%b s=%0d n=%0d expected 1 1 6 1",
               Out_valid, Out_carry, Out_sum, Fifo_count);
    end
    drain();
  endtask

  task automatic test_fill_drop();
    for (int i = 1; i <= 8; i++) cycle(1, 9'(i), 0, 0);
    checks++;
    if (Fifo_full !== 1'b1) begin
      errors++; $display("FAIL fill_full: got %b expected 1", Fifo_full);
    end
    cycle(1, 9'd9, 0, 0);
    checks++;
    if (Drop_count !== 8'd1 || Out_sum !== 8'd1) begin
      errors++; $display("FAIL drop9: got drop=%0d head=%0d expected 1 1", Drop_count, Out_sum);
    end
  endtask

  task automatic test_full_pushpop();
    cycle(1, 9'd20, 1, 0);
    checks++;
    if (Fifo_count !== CNT_W'(8) || Drop_count !== 8'd1) begin
      errors++;
      $display("FAIL full_pushpop: got cnt=%0d drop=%0d expected 8 1", Fifo_count, Drop_count);
    end
    drain();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 9'(100 + i), 1, 0);
      checks++;
      if (Fifo_count > CNT_W'(1)) begin
        errors++; $display("FAIL stream_cnt: got %0d expected <=1", Fifo_count);
      end
    end
    drain();
  endtask

  task automatic test_saturate_clear();
    for (int i = 0; i < 8; i++) cycle(1, 9'(30 + i), 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, 9'(i), 0, 0);
    checks++;
    if (Drop_count !== 8'd255) begin
      errors++; $display("FAIL saturate: got %0d expected 255", Drop_count);
    end
    cycle(1, 9'h55, 0, 1);
    checks++;
    if (Drop_count !== 8'd0) begin
      errors++; $display("FAIL clear: got %0d expected 0", Drop_count);
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1, 9'h1A0 + 9'(i), 0, 0);
    #1;
    reset_n = 0;
    #1;
    checks++;
    if ({Out_valid, Out_sum, Out_carry, Fifo_count} !== {1'b0, 8'd0, 1'b0, CNT_W'(0)}) begin
      errors++;
      $display("FAIL async_reset: got v=%b s=%h c=%b n=%0d expected 0 0 0 0",
               Out_valid, Out_sum, Out_carry, Fifo_count);
    end
    exp_q.delete();
    exp_drop = 0;
    #1;
    reset_n = 1;
    cycle(1, 9'h077, 1, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drop();
    test_full_pushpop();
    test_stream();
    test_saturate_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
